// File: rtl/i2c_slave.sv
// I2C slave bridging a two-wire bus to an 8-bit address / 8-bit data memory port.
// One transaction: device address + R/W, memory address, then one data byte.
module i2c_slave #(
    parameter int ID_W = 7,
    parameter int AW   = 8,
    parameter int DW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ID_W-1:0] id,
    input  logic            scl,
    input  logic            sda_i,
    output logic            sda_oe,
    output logic            ce,
    output logic            rden,
    output logic            wren,
    output logic [AW-1:0]   addr,
    output logic [DW-1:0]   wdata,
    input  logic [DW-1:0]   rdata,
    output logic [3:0]      state,
    output logic [7:0]      s_a_b_m
);

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        DEV_ADDR   = 4'd1,
        ACK_DEV    = 4'd2,
        MEM_ADDR   = 4'd3,
        ACK_MEM    = 4'd4,
        READ_DATA  = 4'd5,
        ACK_MASTER = 4'd6,
        WRITE_DATA = 4'd7,
        ACK_WRITE  = 4'd8,
        WAIT       = 4'd9,
        IGNORE     = 4'd10
    } state_t;

    state_t        state_q, state_n;
    logic [3:0]    cnt_q, cnt_n;
    logic [7:0]    shift_q, shift_n;
    logic          rw_q, rw_n;
    logic          ack_q, ack_n;
    logic          rd_cap_q, rd_cap_n;
    logic          sda_oe_n, ce_n, rden_n, wren_n;
    logic [AW-1:0] addr_n;
    logic [DW-1:0] wdata_n;

    logic scl_s1, scl_s2, scl_d;
    logic sda_s1, sda_s2, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] shifted;

    // Bus lines idle high, so the synchronizer resets high to avoid a phantom edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_d  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_d  <= 1'b1;
        end else begin
            // NOTE: non-blocking so each flop samples the previous stage's old value.
            scl_s1 <= scl;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
    assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
    assign shifted   = {shift_q[6:0], sda_s2};

    always_comb begin
        // NOTE: every target gets a default first so no latch is inferred.
        state_n  = state_q;
        cnt_n    = cnt_q;
        shift_n  = shift_q;
        rw_n     = rw_q;
        ack_n    = ack_q;
        rd_cap_n = rden;
        sda_oe_n = sda_oe;
        ce_n     = 1'b0;
        rden_n   = 1'b0;
        wren_n   = 1'b0;
        addr_n   = addr;
        wdata_n  = wdata;

        if (rd_cap_q)
            shift_n = 8'(rdata);

        if (start_det) begin
            state_n  = DEV_ADDR;
            cnt_n    = 4'd0;
            ack_n    = 1'b0;
            rd_cap_n = 1'b0;
            sda_oe_n = 1'b0;
        end else if (stop_det) begin
            state_n  = IDLE;
            cnt_n    = 4'd0;
            ack_n    = 1'b0;
            rd_cap_n = 1'b0;
            sda_oe_n = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: sda_oe_n = 1'b0;
                DEV_ADDR, MEM_ADDR, WRITE_DATA: if (scl_rise) begin
                    shift_n = shifted;
                    cnt_n   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        cnt_n = 4'd0;
                        if (state_q == DEV_ADDR) begin
                            state_n = ACK_DEV;
                        end else if (state_q == MEM_ADDR) begin
                            addr_n  = AW'(shifted);
                            state_n = ACK_MEM;
                        end else begin
                            wdata_n = DW'(shifted);
                            state_n = ACK_WRITE;
                        end
                    end
                end
                ACK_DEV: if (scl_fall) begin
                    if (!ack_q) begin
                        if (shift_q[7:1] == id) begin
                            sda_oe_n = 1'b1;
                            ack_n    = 1'b1;
                            rw_n     = shift_q[0];
                        end else begin
                            state_n = IGNORE;
                        end
                    end else begin
                        sda_oe_n = 1'b0;
                        ack_n    = 1'b0;
                        state_n  = MEM_ADDR;
                    end
                end
                ACK_MEM: if (scl_fall) begin
                    if (!ack_q) begin
                        sda_oe_n = 1'b1;
                        ack_n    = 1'b1;
                        ce_n     = rw_q;
                        rden_n   = rw_q;
                    end else begin
                        ack_n = 1'b0;
                        if (rw_q) begin
                            // The ACK-closing fall also presents the first read bit.
                            sda_oe_n = ~shift_q[7];
                            shift_n  = {shift_q[6:0], 1'b0};
                            cnt_n    = 4'd1;
                            state_n  = READ_DATA;
                        end else begin
                            sda_oe_n = 1'b0;
                            cnt_n    = 4'd0;
                            state_n  = WRITE_DATA;
                        end
                    end
                end
                READ_DATA: if (scl_fall) begin
                    if (cnt_q == 4'd8) begin
                        sda_oe_n = 1'b0;
                        cnt_n    = 4'd0;
                        state_n  = ACK_MASTER;
                    end else begin
                        sda_oe_n = ~shift_q[7];
                        shift_n  = {shift_q[6:0], 1'b0};
                        cnt_n    = cnt_q + 4'd1;
                    end
                end
                ACK_MASTER: begin
                    sda_oe_n = 1'b0;
                    if (scl_rise)
                        state_n = WAIT;
                end
                ACK_WRITE: if (scl_fall) begin
                    if (!ack_q) begin
                        sda_oe_n = 1'b1;
                        ack_n    = 1'b1;
                        ce_n     = 1'b1;
                        wren_n   = 1'b1;
                    end else begin
                        sda_oe_n = 1'b0;
                        ack_n    = 1'b0;
                        state_n  = WAIT;
                    end
                end
                WAIT, IGNORE: sda_oe_n = 1'b0;
                default: begin
                    state_n  = IDLE;
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            shift_q  <= 8'd0;
            rw_q     <= 1'b0;
            ack_q    <= 1'b0;
            rd_cap_q <= 1'b0;
            sda_oe   <= 1'b0;
            ce       <= 1'b0;
            rden     <= 1'b0;
            wren     <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            shift_q  <= shift_n;
            rw_q     <= rw_n;
            ack_q    <= ack_n;
            rd_cap_q <= rd_cap_n;
            sda_oe   <= sda_oe_n;
            ce       <= ce_n;
            rden     <= rden_n;
            wren     <= wren_n;
            addr     <= addr_n;
            wdata    <= wdata_n;
        end
    end

    assign state   = state_q;
    assign s_a_b_m = shift_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: bit-banged I2C master, behavioural memory, and a
// scoreboard of expected memory accesses and read bytes.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam int TQ = 100;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] id = 7'h01;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_oe, ce, rden, wren;
    logic [7:0] addr, wdata, s_a_b_m;
    logic [7:0] rdata = 8'h00;
    logic [3:0] state;
    wire        sda_bus = sda_m & ~sda_oe;

    i2c_slave dut (
        .clk(clk), .reset(reset), .id(id), .scl(scl_m), .sda_i(sda_bus),
        .sda_oe(sda_oe), .ce(ce), .rden(rden), .wren(wren), .addr(addr),
        .wdata(wdata), .rdata(rdata), .state(state), .s_a_b_m(s_a_b_m)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256] = '{1: 8'hA5, default: 8'h00};
    always @(posedge clk) begin
        if (ce && rden) rdata <= mem[addr];
        if (ce && wren) mem[addr] <= wdata;
    end

    // Strobe monitor: logs every memory access the DUT makes.
    int          wr_cycles = 0, rd_cycles = 0, rd_pulses = 0, ce_bad = 0, oe_cnt = 0;
    logic        rden_prev = 1'b0;
    logic [15:0] wr_log [16];
    logic [7:0]  rd_log [16];
    always @(negedge clk) begin
        if (wren) begin
            if (wr_cycles < 16) wr_log[wr_cycles] = {addr, wdata};
            wr_cycles++;
        end
        if (rden) begin
            if (rd_cycles < 16) rd_log[rd_cycles] = addr;
            rd_cycles++;
            if (!rden_prev) rd_pulses++;
        end
        rden_prev = rden;
        if (ce !== (rden | wren)) ce_bad++;
        if (sda_oe) oe_cnt++;
    end

    int n_checks = 0, n_errors = 0;
    int wr_ptr = 0, rd_ptr = 0;
    logic [15:0] exp_wr [$];
    logic [15:0] exp_rd [$];
    logic [7:0]  model_mem [256] = '{1: 8'hA5, default: 8'h00};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bit_out(input logic b, output logic seen);
        sda_m = b;
        #TQ scl_m = 1'b1;
        #TQ;
        @(negedge clk) seen = sda_bus;
        #TQ scl_m = 1'b0;
        #TQ;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bit_out(b[i], s);
        bit_out(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        logic [7:0] t;
        for (int i = 7; i >= 0; i--) begin
            bit_out(1'b1, s);
            t[i] = s;
        end
        bit_out(nack, s);
        d = t;
    endtask

    task automatic start_cond();
        sda_m = 1'b1;
        #TQ scl_m = 1'b1;
        #TQ sda_m = 1'b0;
        #TQ scl_m = 1'b0;
        #TQ;
    endtask

    task automatic stop_cond();
        sda_m = 1'b0;
        #TQ scl_m = 1'b1;
        #TQ sda_m = 1'b1;
        #TQ;
    endtask

    task automatic expect_write(input logic [7:0] a, input logic [7:0] d);
        exp_wr.push_back({a, d});
        model_mem[a] = d;
    endtask

    task automatic match_writes();
        logic [15:0] e;
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            if (wr_ptr < wr_cycles) begin
                check("wr_addr", wr_log[wr_ptr][15:8], e[15:8]);
                check("wr_data", wr_log[wr_ptr][7:0], e[7:0]);
            end else begin
                check("wr_strobe_seen", wr_cycles, wr_ptr + 1);
            end
            wr_ptr++;
        end
    endtask

    task automatic match_read(input string tag, input logic [7:0] d, input logic data_valid);
        logic [15:0] e;
        e = exp_rd.pop_front();
        if (data_valid) check({tag, "_data"}, d, e[7:0]);
        if (rd_ptr < rd_cycles) check({tag, "_addr"}, rd_log[rd_ptr], e[15:8]);
        else check({tag, "_strobe_seen"}, rd_cycles, rd_ptr + 1);
        rd_ptr++;
    endtask

    task automatic read_txn(input string tag, input logic [7:0] a, input logic with_start);
        logic ack;
        logic [7:0] d;
        if (with_start) start_cond();
        send_byte({id, 1'b1}, ack);
        check({tag, "_dev_ack"}, ack, 1'b1);
        send_byte(a, ack);
        check({tag, "_mem_ack"}, ack, 1'b1);
        exp_rd.push_back({a, model_mem[a]});
        read_byte(1'b1, d);
        match_read(tag, d, 1'b1);
    endtask

    initial begin
        logic ack, s;
        int snap;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_state", state, 4'd0);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_strobes", {ce, rden, wren}, 3'b000);
        check("rst_shift", s_a_b_m, 8'h00);
        check("rst_addr_wdata", {addr, wdata}, 16'h0000);
        repeat (20) @(negedge clk);
        check("idle_state", state, 4'd0);
        check("idle_no_strobe", rd_cycles + wr_cycles, 0);

        // Read of preloaded location, master NACK, STOP.
        read_txn("rd1", 8'h01, 1'b1);
        stop_cond();
        @(negedge clk);
        check("rd1_end_state", state, 4'd0);
        check("rd1_end_oe", sda_oe, 1'b0);

        // Write 0x7F to 0x02, then repeated START and read it back.
        start_cond();
        send_byte(8'h02, ack);
        check("wr_dev_ack", ack, 1'b1);
        send_byte(8'h02, ack);
        check("wr_mem_ack", ack, 1'b1);
        expect_write(8'h02, 8'h7F);
        send_byte(8'h7F, ack);
        check("wr_data_ack", ack, 1'b1);
        match_writes();
        check("wr_wait_state", state, 4'd9);
        read_txn("rd2", 8'h02, 1'b1);
        stop_cond();

        // Foreign device address: no ACK, IGNORE until STOP.
        snap = oe_cnt;
        start_cond();
        send_byte(8'h05, ack);
        check("ign_no_ack", ack, 1'b0);
        check("ign_state", state, 4'd10);
        send_byte(8'h01, ack);
        check("ign_still", state, 4'd10);
        check("ign_oe_cycles", oe_cnt - snap, 0);
        stop_cond();
        @(negedge clk);
        check("ign_end_state", state, 4'd0);

        // STOP after half a write data byte: no memory write.
        start_cond();
        send_byte(8'h02, ack);
        send_byte(8'h03, ack);
        check("abw_mem_ack", ack, 1'b1);
        for (int i = 0; i < 4; i++) bit_out(1'b1, s);
        stop_cond();
        @(negedge clk);
        check("abw_state", state, 4'd0);
        check("abw_oe", sda_oe, 1'b0);

        // Reset in the middle of READ_DATA.
        start_cond();
        send_byte(8'h03, ack);
        send_byte(8'h01, ack);
        exp_rd.push_back({8'h01, model_mem[8'h01]});
        for (int i = 0; i < 3; i++) bit_out(1'b1, s);
        check("abr_in_read", state, 4'd5);
        match_read("abr", 8'h00, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abr_rst_state", state, 4'd0);
        check("abr_rst_oe", sda_oe, 1'b0);
        reset = 1'b0;
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (20) @(negedge clk);
        check("abr_after_state", state, 4'd0);

        check("wr_total", wr_cycles, wr_ptr);
        check("rd_total", rd_cycles, rd_ptr);
        check("rd_one_clk_pulses", rd_pulses, rd_cycles);
        check("ce_only_with_strobe", ce_bad, 0);
        check("scoreboard_empty", exp_wr.size() + exp_rd.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
